// File: rtl/mem_bus_arbiter.sv
// Two-channel memory arbiter: instruction fetch and data share one memory port, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin arbitration; default build gives data fixed priority over fetch.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     inst_addr,
    input  logic                  inst_req_valid,
    output logic                  inst_req_ready,
    output logic [DATA_W-1:0]     inst_rdata,
    output logic                  inst_rvalid,
    input  logic                  inst_rready,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic                  data_wen,
    input  logic                  data_ren,
    input  logic [DATA_W-1:0]     data_wdata,
    input  logic [DATA_W/8-1:0]   data_strb,
    output logic                  data_req_ready,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  data_rvalid,
    input  logic                  data_rready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_strb,
    input  logic                  mem_req_ready,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  mem_rready,
    output logic [31:0]           conflict_cnt
);
    // state | meaning
    // IDLE  | no transaction; arbitrate and latch owner and kind
    // REQ   | request presented downstream, waiting for mem_req_ready
    // RESP  | read issued, waiting for response handshake with the owner
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_t;

    state_t      state;
    owner_t      owner;
    logic        is_write;
    logic [31:0] conflict_q;
    logic        data_req;
    logic        inst_req;
    logic        grant_data;
    logic        own_data;

    assign data_req = data_wen | data_ren;
    assign inst_req = inst_req_valid;
    assign own_data = (owner == OWN_DATA);

`ifdef MEM_ARB_RR_EN
    owner_t last_owner;

    // On conflict the requester that did not win last time gets the port.
    assign grant_data = data_req & (~inst_req | (last_owner == OWN_INST));

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= OWN_DATA;
        end else if (state == IDLE && (inst_req | data_req)) begin
            last_owner <= grant_data ? OWN_DATA : OWN_INST;
        end
    end
`else
    assign grant_data = data_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_INST;
            is_write   <= 1'b0;
            conflict_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (inst_req & data_req) conflict_q <= conflict_q + 32'd1;
                    if (inst_req | data_req) begin
                        owner    <= grant_data ? OWN_DATA : OWN_INST;
                        is_write <= grant_data & data_wen;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) state <= is_write ? IDLE : RESP;
                end
                RESP: begin
                    if (mem_rvalid & mem_rready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address and write data follow the owner's live buses while in REQ.
    always_comb begin
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_strb       = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        mem_rready     = 1'b0;
        inst_req_ready = 1'b0;
        data_req_ready = 1'b0;
        inst_rvalid    = 1'b0;
        data_rvalid    = 1'b0;
        case (state)
            REQ: begin
                mem_addr = own_data ? data_addr : inst_addr;
                if (own_data) begin
                    mem_wdata = data_wdata;
                    mem_strb  = data_strb;
                end
                mem_write      = is_write;
                mem_read       = ~is_write;
                inst_req_ready = ~own_data & mem_req_ready;
                data_req_ready = own_data & mem_req_ready;
            end
            RESP: begin
                mem_rready  = own_data ? data_rready : inst_rready;
                inst_rvalid = ~own_data & mem_rvalid;
                data_rvalid = own_data & mem_rvalid;
            end
            default: ;
        endcase
    end

    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign conflict_cnt = conflict_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level memory/arbitration model.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr;
    logic        inst_req_valid, inst_req_ready, inst_rvalid, inst_rready;
    logic [31:0] inst_rdata;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_wen, data_ren, data_req_ready, data_rvalid, data_rready;
    logic [3:0]  data_strb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read, mem_req_ready, mem_rvalid, mem_rready;
    logic [3:0]  mem_strb;
    logic [31:0] conflict_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_model [16];
    bit          last_data;
    int          exp_conflicts;
    bit          grant_log [$];

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_addr(inst_addr), .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
        .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid), .inst_rready(inst_rready),
        .data_addr(data_addr), .data_wen(data_wen), .data_ren(data_ren), .data_wdata(data_wdata),
        .data_strb(data_strb), .data_req_ready(data_req_ready), .data_rdata(data_rdata),
        .data_rvalid(data_rvalid), .data_rready(data_rready),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read), .mem_wdata(mem_wdata),
        .mem_strb(mem_strb), .mem_req_ready(mem_req_ready), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .conflict_cnt(conflict_cnt)
    );

    task automatic idle_inputs();
        inst_addr = '0; inst_req_valid = 1'b0; inst_rready = 1'b0;
        data_addr = '0; data_wen = 1'b0; data_ren = 1'b0; data_wdata = '0; data_strb = '0;
        data_rready = 1'b0; mem_req_ready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_conflicts = 0;
        last_data = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({inst_req_ready, inst_rvalid, data_req_ready, data_rvalid, mem_write, mem_read, mem_rready,
             mem_addr, mem_wdata, mem_strb, conflict_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rr=%b/%b rv=%b/%b w=%b r=%b rrdy=%b addr=%h cnt=%0d, expected all 0",
                     inst_req_ready, data_req_ready, inst_rvalid, data_rvalid, mem_write, mem_read,
                     mem_rready, mem_addr, conflict_cnt);
        end
        mem_rdata = 32'h5A5A1234;
        #1;
        checks++;
        if (inst_rdata !== 32'h5A5A1234 || data_rdata !== 32'h5A5A1234) begin
            errors++;
            $display("FAIL rdata_passthru: inst=%h data=%h expected 5a5a1234", inst_rdata, data_rdata);
        end
        mem_rdata = '0;
    endtask

    task automatic test_lone_fetch();
        @(negedge clk);
        inst_addr = 32'h100; inst_req_valid = 1'b1; mem_req_ready = 1'b1; inst_rready = 1'b1;
        #1;
        checks++;
        if ({mem_read, mem_write, inst_req_ready, data_rvalid} !== 4'b0000) begin
            errors++;
            $display("FAIL fetch_cycle0: rd=%b wr=%b irdy=%b drv=%b expected 0", mem_read, mem_write, inst_req_ready, data_rvalid);
        end
        @(negedge clk); #1;
        checks++;
        if ({mem_read, mem_write, mem_addr, inst_req_ready, data_req_ready, data_rvalid} !== {2'b10, 32'h100, 3'b100}) begin
            errors++;
            $display("FAIL fetch_cycle1: rd=%b wr=%b addr=%h irdy=%b drdy=%b drv=%b expected rd=1 addr=100 irdy=1",
                     mem_read, mem_write, mem_addr, inst_req_ready, data_req_ready, data_rvalid);
        end
        @(negedge clk);
        inst_req_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h24020005;
        #1;
        checks++;
        if ({inst_rvalid, inst_rdata, data_rvalid, mem_rready} !== {1'b1, 32'h24020005, 2'b01}) begin
            errors++;
            $display("FAIL fetch_cycle2: irv=%b rdata=%h drv=%b mrrdy=%b expected 1 24020005 0 1",
                     inst_rvalid, inst_rdata, data_rvalid, mem_rready);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        checks++;
        if ({mem_read, inst_rvalid, data_rvalid, mem_rready} !== 4'b0000) begin
            errors++;
            $display("FAIL fetch_done: rd=%b irv=%b drv=%b mrrdy=%b expected 0", mem_read, inst_rvalid, data_rvalid, mem_rready);
        end
        idle_inputs();
        last_data = 1'b0;
    endtask

    task automatic test_lone_store();
        int pulses = 0;
        @(negedge clk);
        data_addr = 32'h2000; data_wdata = 32'hDEADBEEF; data_strb = 4'b0011; data_wen = 1'b1;
        mem_req_ready = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            mem_req_ready = (c == 4);
            #1;
            checks++;
            if ({mem_write, mem_read, mem_addr, mem_wdata, mem_strb} !== {2'b10, 32'h2000, 32'hDEADBEEF, 4'b0011}) begin
                errors++;
                $display("FAIL store_req c%0d: wr=%b rd=%b addr=%h wdata=%h strb=%b expected 1 0 2000 deadbeef 0011",
                         c, mem_write, mem_read, mem_addr, mem_wdata, mem_strb);
            end
            if (data_req_ready) pulses++;
        end
        @(negedge clk);
        data_wen = 1'b0; mem_req_ready = 1'b0; mem_rvalid = 1'b1; data_rready = 1'b1;
        #1;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL store_ready_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if ({mem_write, mem_read, mem_rready, data_rvalid} !== 4'b0000) begin
            errors++;
            $display("FAIL store_no_resp: wr=%b rd=%b mrrdy=%b drv=%b expected 0", mem_write, mem_read, mem_rready, data_rvalid);
        end
        idle_inputs();
        last_data = 1'b1;
    endtask

    // One round of requests driven to completion against the memory/arbitration model.
    task automatic run_round(input bit want_inst, input bit want_data, input bit d_wen, input bit d_ren, input bit rnd);
        bit          inst_pend, data_pend, resp_pend, resp_owner, in_req, cur_owner, exp_owner, exp_wr;
        int          delay, cyc;
        logic [31:0] resp_data;
        logic [71:0] got, exp;
        inst_pend = want_inst;
        data_pend = want_data && (d_wen || d_ren);
        resp_pend = 1'b0; in_req = 1'b0; cur_owner = 1'b0; resp_owner = 1'b0; delay = 0; resp_data = '0;
        @(negedge clk);
        inst_addr  = 32'($urandom_range(0, 7)) * 4;
        data_addr  = 32'($urandom_range(8, 15)) * 4;
        data_wdata = $urandom;
        data_strb  = 4'($urandom_range(0, 15));
        if (inst_pend && data_pend) exp_conflicts++;
        cyc = 0;
        while ((inst_pend || data_pend || resp_pend) && cyc < 200) begin
            if (cyc > 0) @(negedge clk);
            inst_req_valid = inst_pend;
            data_wen       = data_pend & d_wen;
            data_ren       = data_pend & d_ren;
            mem_req_ready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            inst_rready    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            data_rready    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (resp_pend && delay == 0) begin
                mem_rvalid = 1'b1; mem_rdata = resp_data;
            end else begin
                mem_rvalid = (!resp_pend && rnd) ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_rdata  = $urandom;
            end
            #1;
            // response side
            if (resp_pend && delay == 0) begin
                checks++;
                if ({inst_rvalid, data_rvalid, mem_rready} !== {!resp_owner, resp_owner, resp_owner ? data_rready : inst_rready}
                    || (resp_owner ? data_rdata : inst_rdata) !== resp_data) begin
                    errors++;
                    $display("FAIL resp: irv=%b drv=%b mrrdy=%b idata=%h ddata=%h owner=%0b expected data %h",
                             inst_rvalid, data_rvalid, mem_rready, inst_rdata, data_rdata, resp_owner, resp_data);
                end
                if (resp_owner ? data_rready : inst_rready) resp_pend = 1'b0;
            end else begin
                checks++;
                if ({inst_rvalid, data_rvalid} !== 2'b00 || (!resp_pend && mem_rready !== 1'b0)) begin
                    errors++;
                    $display("FAIL resp_idle: irv=%b drv=%b mrrdy=%b pend=%0b expected no response",
                             inst_rvalid, data_rvalid, mem_rready, resp_pend);
                end
            end
            if (resp_pend && delay > 0) delay--;
            // request side
            if (mem_read || mem_write) begin
                if (!in_req) begin
`ifdef MEM_ARB_RR_EN
                    exp_owner = (inst_pend && data_pend) ? !last_data : data_pend;
`else
                    exp_owner = data_pend;
`endif
                    cur_owner = exp_owner;
                    last_data = exp_owner;
                    grant_log.push_back(exp_owner);
                    in_req = 1'b1;
                    checks++;
                    if (resp_pend || !(inst_pend || data_pend)) begin
                        errors++;
                        $display("FAIL grant_when_busy: resp_pend=%0b ipend=%0b dpend=%0b expected no grant", resp_pend, inst_pend, data_pend);
                    end
                end
                exp_wr = cur_owner && d_wen;
                exp = {exp_wr, !exp_wr, cur_owner ? data_addr : inst_addr, cur_owner ? data_wdata : 32'h0,
                       cur_owner ? data_strb : 4'h0, !cur_owner && mem_req_ready, cur_owner && mem_req_ready};
                got = {mem_write, mem_read, mem_addr, mem_wdata, mem_strb, inst_req_ready, data_req_ready};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL grant owner=%0b: got %h expected %h", cur_owner, got, exp);
                end
                if (mem_req_ready) begin
                    in_req = 1'b0;
                    if (cur_owner) data_pend = 1'b0; else inst_pend = 1'b0;
                    if (exp_wr) begin
                        for (int b = 0; b < 4; b++)
                            if (data_strb[b]) mem_model[data_addr[5:2]][8*b +: 8] = data_wdata[8*b +: 8];
                    end else begin
                        resp_pend  = 1'b1;
                        resp_owner = cur_owner;
                        resp_data  = mem_model[cur_owner ? data_addr[5:2] : inst_addr[5:2]];
                        delay      = rnd ? $urandom_range(0, 2) : 0;
                    end
                end
            end else begin
                checks++;
                if (in_req || cyc == 1 || inst_req_ready || data_req_ready) begin
                    errors++;
                    $display("FAIL no_grant: cyc=%0d in_req=%0b irdy=%b drdy=%b expected grant state consistent",
                             cyc, in_req, inst_req_ready, data_req_ready);
                end
            end
            cyc++;
        end
        if (cyc >= 200) begin
            errors++;
            $display("FAIL round_timeout: %0d cycles, expected completion", cyc);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (conflict_cnt !== 32'(exp_conflicts)) begin
            errors++;
            $display("FAIL conflict_cnt: got %0d expected %0d", conflict_cnt, exp_conflicts);
        end
    endtask

    task automatic test_conflict();
        bit exp_order [4];
`ifdef MEM_ARB_RR_EN
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
        do_reset();
        grant_log.delete();
        run_round(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        run_round(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (grant_log.size() != 4) begin
            errors++;
            $display("FAIL grant_count: got %0d expected 4", grant_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grant_log[i] != exp_order[i]) begin
                    errors++;
                    $display("FAIL grant_order[%0d]: got owner %0b expected %0b", i, grant_log[i], exp_order[i]);
                end
            end
        end
        checks++;
        if (conflict_cnt !== 32'd2) begin
            errors++;
            $display("FAIL conflict_two: got %0d expected 2", conflict_cnt);
        end
    endtask

    task automatic test_backpressure();
        int done = 0;
        @(negedge clk);
        data_addr = 32'h300; data_ren = 1'b1; mem_req_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({mem_read, data_req_ready} !== 2'b11) begin
            errors++;
            $display("FAIL bp_issue: rd=%b drdy=%b expected 1 1", mem_read, data_req_ready);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            data_ren = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001; data_rready = (c == 4);
            #1;
            checks++;
            if ({data_rvalid, mem_rready, mem_read, data_rdata} !== {1'b1, c == 4, 1'b0, 32'hCAFE0001}) begin
                errors++;
                $display("FAIL bp_resp c%0d: drv=%b mrrdy=%b rd=%b data=%h expected 1 %0b 0 cafe0001",
                         c, data_rvalid, mem_rready, mem_read, data_rdata, c == 4);
            end
            if (data_rvalid && data_rready) done++;
        end
        @(negedge clk);
        #1;
        if (data_rvalid && data_rready) done++;
        checks++;
        if (done != 1 || mem_rready !== 1'b0) begin
            errors++;
            $display("FAIL bp_complete: loads=%0d mrrdy=%b expected 1 load and mrrdy 0", done, mem_rready);
        end
        idle_inputs();
        last_data = 1'b1;
    endtask

    task automatic test_random();
        int kind;
        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(0, 2);
            run_round(kind != 1, kind != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        inst_addr = 32'h40; inst_req_valid = 1'b1; mem_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        inst_req_valid = 1'b0; mem_req_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11112222;
        inst_rready = 1'b0; rst = 1'b1;
        #1;
        checks++;
        if (inst_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_resp: irv=%b expected 1", inst_rvalid);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if ({inst_req_ready, inst_rvalid, data_req_ready, data_rvalid, mem_write, mem_read, mem_rready,
             mem_addr, mem_wdata, mem_strb, conflict_cnt} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: irv=%b rd=%b mrrdy=%b addr=%h cnt=%0d expected all 0",
                     inst_rvalid, mem_read, mem_rready, mem_addr, conflict_cnt);
        end
        exp_conflicts = 0;
        last_data = 1'b1;
        grant_log.delete();
        run_round(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (grant_log.size() != 1) begin
            errors++;
            $display("FAIL rstmid_fetch: grants=%0d expected 1", grant_log.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
        rst = 1'b1;
        test_reset();
        test_lone_fetch();
        test_lone_store();
        test_conflict();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one memory port between the CPU instruction-fetch channel and the CPU data channel.
- Sits between custom_cpu and the memory/bus bridge.
- One transaction in flight at a time. The response is routed back to the requester that owns the grant.
- Keeps a conflict counter that can be wired to a spare cpu_perf_cnt output.

Parameters:
ADDR_W, 32, address width of all channels
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous, active-high reset
inst_addr  input  ADDR_W  fetch address (PC)
inst_req_valid  input  1  fetch request
inst_req_ready  output  1  fetch request accepted
inst_rdata  output  DATA_W  fetch response data
inst_rvalid  output  1  fetch response valid
inst_rready  input  1  fetch response accepted
data_addr  input  ADDR_W  load/store address
data_wen  input  1  store request (MemWrite)
data_ren  input  1  load request (MemRead)
data_wdata  input  DATA_W  store data
data_strb  input  DATA_W/8  store byte strobes
data_req_ready  output  1  load/store request accepted
data_rdata  output  DATA_W  load response data
data_rvalid  output  1  load response valid
data_rready  input  1  load response accepted
mem_addr  output  ADDR_W  downstream address
mem_write  output  1  downstream write request
mem_read  output  1  downstream read request
mem_wdata  output  DATA_W  downstream write data
mem_strb  output  DATA_W/8  downstream strobes
mem_req_ready  input  1  downstream request accepted
mem_rdata  input  DATA_W  downstream read data
mem_rvalid  input  1  downstream read data valid
mem_rready  output  1  downstream read data accepted
conflict_cnt  output  32  count of cycles in which both requesters competed

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- State machine: IDLE -> REQ -> (RESP) -> IDLE. The state register and owner register (INST/DATA) are reset to IDLE/INST.
- Request decode: data_req = data_wen | data_ren; inst_req = inst_req_valid. If data_wen and data_ren are both set, treat the request as a write.
- IDLE:
  - If any request is present, latch the owner, latch the request kind (write/read), and move to REQ.
  - Arbitration is fixed: data beats inst.
  - All ready/valid outputs to both requesters are 0. mem_read, mem_write and mem_rready are 0.
- REQ:
  - mem_addr, mem_wdata and mem_strb are muxed from the owner. inst drives strb = 0 and wdata = 0.
  - mem_write = latched write kind. mem_read = latched read kind.
  - The owner's req_ready = mem_req_ready. The non-owner's req_ready = 0.
  - On mem_req_ready: a write goes to IDLE; a read goes to RESP.
- RESP:
  - mem_rready = owner's rready.
  - Owner's rvalid = mem_rvalid; owner's rdata = mem_rdata.
  - On mem_rvalid & mem_rready, go to IDLE.
  - The non-owner's rvalid is 0.
- Data path: rdata outputs are driven by mem_rdata for both requesters at all times. Only the rvalid outputs are gated.
- Latency:
  - A request seen in IDLE at cycle t is presented downstream at t+1.
  - Minimum read turnaround is 3 cycles (IDLE, REQ, RESP). Minimum write turnaround is 2 cycles.
- Request stability: requesters hold their address, data and request stable until req_ready. The arbiter does not re-sample the owner's signals after IDLE, except the muxed data buses.
- Stray response: mem_rvalid outside RESP is ignored, and mem_rready stays 0.
- Loser: a losing requester simply waits in its handshake state. It is never dropped.
- conflict_cnt:
  - Increments by 1 in each IDLE cycle with inst_req & data_req. Wraps at 2^32.
  - Reset to 0.
- Reset mid-transaction: rst in REQ or RESP returns to IDLE next cycle and abandons the outstanding response. Downstream must also be reset.
- Output reset values: all outputs are 0 after reset.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- When defined:
  - Arbitration is round-robin via a last_owner register, reset to DATA.
  - On conflict in IDLE, the requester that is not last_owner wins.
  - last_owner updates whenever the arbiter leaves IDLE.
- When undefined: fixed data-over-inst priority, and no last_owner register exists.

Test Plan:
- Lone fetch, inst_addr=0x100, mem_req_ready=1, mem_rdata=0x24020005 valid one cycle after REQ:
  -> mem_read=1 with mem_addr=0x100 in cycle 1.
  -> inst_rvalid=1 with inst_rdata=0x24020005 in cycle 2.
  -> data_rvalid=0 throughout.
- Lone store, data_addr=0x2000, data_wdata=0xDEADBEEF, data_strb=4'b0011, mem_req_ready held 0 for 3 cycles:
  -> mem_write=1, mem_strb=4'b0011, mem_wdata=0xDEADBEEF held 3 cycles.
  -> data_req_ready pulses once.
  -> State returns to IDLE; no RESP state.
- Simultaneous fetch and load in IDLE:
  -> Load is granted first and inst waits.
  -> Fetch is issued after the load response handshake.
  -> conflict_cnt = 1.
- Same as above with MEM_ARB_RR_EN, repeated twice back-to-back:
  -> Grant order is inst (last_owner reset DATA), then data, then inst, then data.
  -> conflict_cnt = 2.
- Response backpressure: data_rready=0 for 4 cycles while mem_rvalid=1:
  -> mem_rready = 0 for those cycles.
  -> State stays RESP.
  -> Exactly one load completes when data_rready rises.
- rst asserted in RESP with mem_rvalid pending:
  -> Next cycle is IDLE with all outputs 0.
  -> conflict_cnt = 0.
  -> A following fetch completes normally.
